pantalla_wb_master: RTL

Wishbone classic single-cycle initiator that turns a stream of queued register commands into bus cycles toward display-style Wishbone slaves (address window 0x00–0x14). It sits between a command source (sequencer, UART bridge or test harness) and the slave's Wishbone port. It buffers commands in a small FIFO and runs one read or write cycle per command. It returns a response for every command, including read data and timeout errors.

---
 rtl/pantalla_wb_pkg.sv | 20 ++
 rtl/wb_cmd_fifo.sv | 53 +++++
 rtl/pantalla_wb_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pantalla_wb_pkg.sv
// Shared definitions for the pantalla Wishbone command initiator:
// FSM state encoding, byte-select constant and slave register map.
package pantalla_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  localparam logic [31:0] REG_00 = 32'h0000_0000;
  localparam logic [31:0] REG_04 = 32'h0000_0004;
  localparam logic [31:0] REG_08 = 32'h0000_0008;
  localparam logic [31:0] REG_0C = 32'h0000_000C;
  localparam logic [31:0] REG_10 = 32'h0000_0010;
  localparam logic [31:0] REG_14 = 32'h0000_0014;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; entries are {we, adr, dat}. The head entry is
// visible on rd_data whenever the FIFO is non-empty.
module wb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pantalla_wb_master.sv
// Wishbone classic initiator: pops queued register commands and runs one
// single read/write bus cycle per command, reporting data or timeout.
module pantalla_wb_master
  import pantalla_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;

  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [64:0]   head;

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (65)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid),
    .pop     (pop),
    .wr_data ({cmd_we, cmd_adr, cmd_dat}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign cmd_ready = ~full;
  assign busy      = (count != '0) || (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          we_d    = head[64];
          adr_d   = head[63:32];
          dat_d   = head[64] ? head[31:0] : 32'h0;
          sel_d   = WB_SEL_ALL;
          cyc_d   = 1'b1;
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          sel_d       = 4'h0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timer_q == T_LAST) begin
          cyc_d       = 1'b0;
          sel_d       = 4'h0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      sel_q       <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule
